// File: rtl/uart_pkg.sv
// Shared UART receive definitions: controller state encoding and bit/character timing.
// Timing helpers are constant functions so parameters can size counters at elaboration.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED   = 2'd0,
    ST_ACTIVE     = 2'd1,
    ST_BREAK_WAIT = 2'd2
  } state_t;

  function automatic int baud_ticks(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  // One character on the line is start + payload + stop.
  function automatic int char_ticks(input int clk_hz, input int bit_rate, input int payload_bits);
    return baud_ticks(clk_hz, bit_rate) * (payload_bits + 2);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through buffer; head valid the cycle after a push.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers are AW bits wide, so wrap is implicit for power-of-two depths.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable/break FSM, receive buffer, sticky flags and idle timer.
// Characters appear on m_valid one cycle after the strobe; m_ready stalls the buffer head.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int IDLE_CHARS   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          rxd_mon,
  output logic                          rx_en,
  input  logic [PAYLOAD_BITS-1:0]       rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_break,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          break_seen,
  output logic                          idle_timeout
);

  localparam int BAUD_TICKS = baud_ticks(CLK_HZ, BIT_RATE);
  localparam int TIMEOUT    = IDLE_CHARS * char_ticks(CLK_HZ, BIT_RATE, PAYLOAD_BITS);
  localparam int BW         = $clog2(BAUD_TICKS + 1);
  localparam int TW         = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  state_t        state;
  logic [BW-1:0] brk_cnt;
  logic [TW-1:0] idle_cnt;
  logic          armed;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          brk_req;
  logic          drop;

  assign push_req = (state == ST_ACTIVE) && rx_valid && !rx_break;
  assign brk_req  = (state == ST_ACTIVE) && rx_valid && rx_break;
  assign pop      = m_valid && m_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign m_valid  = !empty;

  uart_rx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_req),
    .push_data (rx_data),
    .pop       (pop),
    .head      (m_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // BREAK_WAIT needs a full bit time of unbroken idle line before re-arming the receiver.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_DISABLED;
      rx_en   <= 1'b0;
      brk_cnt <= '0;
    end else if (!enable) begin
      state   <= ST_DISABLED;
      rx_en   <= 1'b0;
      brk_cnt <= '0;
    end else begin
      case (state)
        ST_DISABLED: begin
          state <= ST_ACTIVE;
          rx_en <= 1'b1;
        end
        ST_ACTIVE: begin
          if (brk_req) begin
            state   <= ST_BREAK_WAIT;
            rx_en   <= 1'b0;
            brk_cnt <= '0;
          end
        end
        ST_BREAK_WAIT: begin
          if (!rxd_mon) begin
            brk_cnt <= '0;
          end else if (brk_cnt == BAUD_LAST) begin
            state   <= ST_ACTIVE;
            rx_en   <= 1'b1;
            brk_cnt <= '0;
          end else begin
            brk_cnt <= brk_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_DISABLED;
          rx_en <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear takes priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      break_seen <= 1'b0;
    end else begin
      if (drop)       overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
      if (brk_req)    break_seen <= 1'b1;
      else if (clear) break_seen <= 1'b0;
    end
  end

  // Idle timer only advances while receiving; it freezes outside ACTIVE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt     <= '0;
      armed        <= 1'b0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= 1'b0;
      if (push_ok) begin
        idle_cnt <= '0;
        armed    <= 1'b1;
      end else if (armed && state == ST_ACTIVE) begin
        if (idle_cnt == TO_LAST) begin
          idle_timeout <= 1'b1;
          armed        <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 1 MHz / 100 kbit/s, depth 4, 2 idle characters.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic       clear;
  logic       rxd_mon;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_break;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] level;
  logic       overflow;
  logic       break_seen;
  logic       idle_timeout;

  int checks;
  int failures;

  uart_rx_ctrl #(
    .CLK_HZ       (1_000_000),
    .BIT_RATE     (100_000),
    .PAYLOAD_BITS (8),
    .FIFO_DEPTH   (4),
    .IDLE_CHARS   (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .clear        (clear),
    .rxd_mon      (rxd_mon),
    .rx_en        (rx_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_break     (rx_break),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .overflow     (overflow),
    .break_seen   (break_seen),
    .idle_timeout (idle_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle receiver strobe; returns at the negedge after the sampling posedge.
  task automatic strobe(input logic [7:0] d, input logic brk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_break = brk;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    int first_hit;
    int pulses;

    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    rxd_mon  = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    m_ready  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_break", break_seen, 0);
    chk("rst_timeout", idle_timeout, 0);
    resetn = 1'b1;

    // Basic ordering and FWFT hold
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("en_rx_en", rx_en, 1);
    strobe(8'h41, 1'b0);
    chk("lat_m_valid", m_valid, 1);
    strobe(8'h42, 1'b0);
    repeat (3) @(negedge clk);
    chk("two_level", level, 2);
    chk("two_head", m_data, 8'h41);
    m_ready = 1'b1;
    @(negedge clk);
    chk("pop1_data", m_data, 8'h42);
    chk("pop1_level", level, 1);
    @(negedge clk);
    chk("pop2_level", level, 0);
    chk("pop2_valid", m_valid, 0);
    m_ready = 1'b0;

    // Overflow and push-while-full-with-pop
    for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i), 1'b0);
    chk("fill_ovf", overflow, 0);
    strobe(8'h14, 1'b0);
    chk("full_level", level, 4);
    chk("full_ovf", overflow, 1);
    chk("full_head", m_data, 8'h10);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_ovf", overflow, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h15;
    m_ready  = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_ovf", overflow, 0);
    exp_seq[0] = 8'h11;
    exp_seq[1] = 8'h12;
    exp_seq[2] = 8'h13;
    exp_seq[3] = 8'h15;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), m_data, exp_seq[i]);
      @(negedge clk);
    end
    chk("drain_level", level, 0);
    m_ready = 1'b0;

    // Break handling
    strobe(8'h55, 1'b1);
    chk("brk_seen", break_seen, 1);
    chk("brk_rx_en", rx_en, 0);
    chk("brk_level", level, 0);
    strobe(8'h66, 1'b0);
    chk("brk_ignore", level, 0);
    rxd_mon = 1'b1;
    repeat (9) @(negedge clk);
    rxd_mon = 1'b0;
    @(negedge clk);
    rxd_mon = 1'b1;
    chk("brk_9_0", rx_en, 0);
    repeat (9) @(negedge clk);
    chk("brk_9", rx_en, 0);
    @(negedge clk);
    chk("brk_10", rx_en, 1);

    // clear against a coincident overflow drop
    for (int i = 0; i < 4; i++) strobe(8'h20 + 8'(i), 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h24;
    clear    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_drop_ovf", overflow, 1);
    chk("clr_drop_brk", break_seen, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_alone_ovf", overflow, 0);
    chk("clr_alone_brk", break_seen, 0);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    m_ready = 1'b0;
    chk("clr_drain", level, 0);

    // Idle timeout
    strobe(8'h77, 1'b0);
    first_hit = 0;
    pulses    = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (idle_timeout) begin
        pulses++;
        if (first_hit == 0) first_hit = i;
      end
    end
    chk("to_when", first_hit, 200);
    chk("to_count", pulses, 1);

    // Asynchronous reset mid-buffer
    strobe(8'h78, 1'b0);
    strobe(8'h79, 1'b0);
    chk("pre_rst_level", level, 3);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_rx_en", rx_en, 0);
    chk("arst_m_data", m_data, 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BIT_RATE, default 9600, line bit rate.
REQ-003 The block SHALL have parameter PAYLOAD_BITS, default 8, character width.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, receive buffer entries (power of two, >=2).
REQ-005 The block SHALL have parameter IDLE_CHARS, default 4, idle character times before timeout.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-007 The block SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have port enable, input, 1 bit: software receive enable.
REQ-009 The block SHALL have port clear, input, 1 bit: a one-cycle pulse that clears the sticky flags.
REQ-010 The block SHALL have port rxd_mon, input, 1 bit: synchronised copy of the receiver line input.
REQ-011 The block SHALL have port rx_en, output, 1 bit: enable to the UART receiver.
REQ-012 The block SHALL have port rx_data, input, PAYLOAD_BITS: receiver data.
REQ-013 The block SHALL have port rx_valid, input, 1 bit: receiver one-cycle character strobe.
REQ-014 The block SHALL have port rx_break, input, 1 bit: receiver break indication, qualified by rx_valid.
REQ-015 The block SHALL have port m_data, output, PAYLOAD_BITS: head of the buffer.
REQ-016 The block SHALL have port m_valid, output, 1 bit: buffer non-empty.
REQ-017 The block SHALL have port m_ready, input, 1 bit: consumer accept.
REQ-018 The block SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: buffer occupancy.
REQ-019 The block SHALL have ports overflow (output, 1 bit, sticky), break_seen (output, 1 bit, sticky) and idle_timeout (output, 1 bit, one-cycle pulse).

Function
REQ-020 The block SHALL implement states DISABLED, ACTIVE and BREAK_WAIT; rx_en SHALL be 1 only in ACTIVE.
REQ-021 The block SHALL transition DISABLED->ACTIVE when enable=1, and any state->DISABLED when enable=0, in the next cycle.
REQ-022 In ACTIVE, rx_valid=1 with rx_break=0 SHALL push rx_data; m_valid SHALL rise the cycle after the strobe (1-cycle latency).
REQ-023 In ACTIVE, rx_valid=1 with rx_break=1 SHALL push nothing, set break_seen, and move to BREAK_WAIT.
REQ-024 BREAK_WAIT SHALL count consecutive cycles with rxd_mon=1, restarting on any 0, and return to ACTIVE after BAUD_TICKS=CLK_HZ/BIT_RATE such cycles.
REQ-025 Pop SHALL occur when m_valid=1 and m_ready=1; m_data SHALL be first-word-fall-through and held stable while m_valid=1 and m_ready=0.
REQ-026 A push while full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-027 A simultaneous push and pop when not full SHALL leave level unchanged.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-029 The idle counter SHALL reload on every accepted push and arm the timeout; while armed in ACTIVE it SHALL increment each cycle.
REQ-030 At IDLE_CHARS*CHAR_TICKS, where CHAR_TICKS=BAUD_TICKS*(PAYLOAD_BITS+2), idle_timeout SHALL pulse for one cycle and disarm.
REQ-031 clear SHALL zero overflow and break_seen; a set condition in the same cycle as clear SHALL win.
REQ-032 Leaving ACTIVE SHALL retain buffer contents and allow draining to continue; strobes outside ACTIVE SHALL be ignored.

Reset
REQ-033 On resetn=0, asynchronously: state=DISABLED, rx_en=0, m_valid=0, level=0, pointers=0, overflow=0, break_seen=0, idle_timeout=0, counters=0, timeout disarmed.
REQ-034 Reset assertion mid-character or mid-drain SHALL discard all buffered data.

Structure
REQ-035 State encoding and the BAUD_TICKS/CHAR_TICKS derivation SHALL reside in shared package uart_pkg.
REQ-036 The buffer SHALL be a sub-module uart_rx_fifo (sync FWFT, level and full/empty outputs); the controller FSM, break qualifier and idle timer SHALL reside in uart_rx_ctrl.

Verification
(Parameters: CLK_HZ=1_000_000, BIT_RATE=100_000, FIFO_DEPTH=4, IDLE_CHARS=2, giving BAUD_TICKS=10, CHAR_TICKS=100, timeout at 200 cycles.)
REQ-037 enable=1, strobes 0x41, 0x42, m_ready=0 -> level=2, m_data=0x41; then m_ready=1 -> 0x41, 0x42 in order, level=0.
REQ-038 Five strobes with m_ready=0 -> level=4, overflow=1, fifth byte absent; a strobe while full with m_ready=1 -> accepted, overflow unchanged.
REQ-039 Strobe with rx_break=1 -> break_seen=1, rx_en=0, no push; rxd_mon=1 for 9 cycles, a 0, then 10 cycles -> ACTIVE re-entered only after the 10.
REQ-040 One byte, then no strobes -> idle_timeout pulses exactly once, 200 cycles after the push; no further pulse until the next push.
REQ-041 clear coincident with an overflow drop -> overflow=1; clear alone -> overflow=0 and break_seen=0.
REQ-042 resetn pulsed low with level=3 and state ACTIVE -> all outputs at reset values immediately, without waiting for clk.
